// File: rtl/mult_pkg.sv
// Shared definitions for the SIMD multiplier operand-preparation stage.
// Element-width encoding and fixed datapath widths.
package mult_pkg;

  typedef enum logic [1:0] {
    SEW_8    = 2'b00,
    SEW_16   = 2'b01,
    SEW_32   = 2'b10,
    SEW_RSVD = 2'b11
  } sew_e;

  localparam int NUM_MULT = 8;
  localparam int LANE_W   = 8;
  localparam int DATA_W   = 32;

endpackage

// File: rtl/mult_abs.sv
// Two's-complement magnitude/sign extractor, width W.
// Ports: x (element in), mag (|x|, W bits), sign (MSB of x).
// Macro MULT8_SIGNED_EN: defined -> signed magnitude; undefined -> raw pass, sign 0.
module mult_abs #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] mag,
  output logic         sign
);

`ifdef MULT8_SIGNED_EN
  // Most-negative value wraps to itself, which is its unsigned magnitude.
  assign mag  = x[W-1] ? (~x + W'(1)) : x;
  assign sign = x[W-1];
`else
  assign mag  = x;
  assign sign = 1'b0;
`endif

endmodule

// File: rtl/multiplier_8.sv
// Operand-prep stage: splits A/B into eight registered 8x8 operand pairs.
// Ports: clk, reset (async high), data_in_A/B[31:0], sew[1:0], count_0;
// outputs mult1..8_A/B[7:0], sign_A0..3, sign_B0..3. Macro: MULT8_SIGNED_EN.
module multiplier_8
  import mult_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in_A,
  input  logic [31:0] data_in_B,
  input  logic [1:0]  sew,
  input  logic        count_0,
  output logic [7:0]  mult1_A,
  output logic [7:0]  mult2_A,
  output logic [7:0]  mult3_A,
  output logic [7:0]  mult4_A,
  output logic [7:0]  mult5_A,
  output logic [7:0]  mult6_A,
  output logic [7:0]  mult7_A,
  output logic [7:0]  mult8_A,
  output logic [7:0]  mult1_B,
  output logic [7:0]  mult2_B,
  output logic [7:0]  mult3_B,
  output logic [7:0]  mult4_B,
  output logic [7:0]  mult5_B,
  output logic [7:0]  mult6_B,
  output logic [7:0]  mult7_B,
  output logic [7:0]  mult8_B,
  output logic        sign_A0,
  output logic        sign_A1,
  output logic        sign_A2,
  output logic        sign_A3,
  output logic        sign_B0,
  output logic        sign_B1,
  output logic        sign_B2,
  output logic        sign_B3
);

  localparam int OP_W = NUM_MULT * LANE_W;

  logic [DATA_W-1:0] a8_m, b8_m;
  logic [DATA_W-1:0] a16_m, b16_m;
  logic [DATA_W-1:0] a32_m, b32_m;
  logic [3:0]        a8_s, b8_s;
  logic [1:0]        a16_s, b16_s;
  logic              a32_s, b32_s;

  for (genvar g = 0; g < 4; g++) begin : g_e8
    mult_abs #(.W(8)) u_a (
      .x(data_in_A[8*g +: 8]), .mag(a8_m[8*g +: 8]), .sign(a8_s[g]));
    mult_abs #(.W(8)) u_b (
      .x(data_in_B[8*g +: 8]), .mag(b8_m[8*g +: 8]), .sign(b8_s[g]));
  end

  for (genvar g = 0; g < 2; g++) begin : g_e16
    mult_abs #(.W(16)) u_a (
      .x(data_in_A[16*g +: 16]), .mag(a16_m[16*g +: 16]), .sign(a16_s[g]));
    mult_abs #(.W(16)) u_b (
      .x(data_in_B[16*g +: 16]), .mag(b16_m[16*g +: 16]), .sign(b16_s[g]));
  end

  mult_abs #(.W(32)) u_a32 (.x(data_in_A), .mag(a32_m), .sign(a32_s));
  mult_abs #(.W(32)) u_b32 (.x(data_in_B), .mag(b32_m), .sign(b32_s));

  // Byte k of opa/opb is multiplier k+1; sgn = {B3..B0, A3..A0}.
  logic [OP_W-1:0] opa_d, opa_q;
  logic [OP_W-1:0] opb_d, opb_q;
  logic [7:0]      sgn_d, sgn_q;
  logic [7:0]      b32_lo, b32_hi;
  sew_e            sew_w;

  assign sew_w  = sew_e'(sew);
  // Pass select picks which B byte pair feeds this half of the 32x32.
  assign b32_lo = count_0 ? b32_m[23:16] : b32_m[7:0];
  assign b32_hi = count_0 ? b32_m[31:24] : b32_m[15:8];

  always_comb begin
    opa_d = '0;
    opb_d = '0;
    sgn_d = '0;
    unique case (1'b1)
      (sew_w == SEW_8): begin
        opa_d[31:0] = a8_m;
        opb_d[31:0] = b8_m;
        sgn_d       = {b8_s, a8_s};
      end
      (sew_w == SEW_16): begin
        opa_d = {a16_m[31:24], a16_m[31:24],
                 a16_m[23:16], a16_m[23:16],
                 a16_m[15:8],  a16_m[15:8],
                 a16_m[7:0],   a16_m[7:0]};
        opb_d = {b16_m[31:24], b16_m[23:16],
                 b16_m[31:24], b16_m[23:16],
                 b16_m[15:8],  b16_m[7:0],
                 b16_m[15:8],  b16_m[7:0]};
        sgn_d = {2'b00, b16_s, 2'b00, a16_s};
      end
      (sew_w == SEW_32): begin
        opa_d = {a32_m, a32_m};
        opb_d = {{4{b32_hi}}, {4{b32_lo}}};
        sgn_d = {3'b000, b32_s, 3'b000, a32_s};
      end
      default: begin
        opa_d = '0;
        opb_d = '0;
        sgn_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opa_q <= '0;
      opb_q <= '0;
      sgn_q <= '0;
    end else begin
      opa_q <= opa_d;
      opb_q <= opb_d;
      sgn_q <= sgn_d;
    end
  end

  assign {mult8_A, mult7_A, mult6_A, mult5_A,
          mult4_A, mult3_A, mult2_A, mult1_A} = opa_q;
  assign {mult8_B, mult7_B, mult6_B, mult5_B,
          mult4_B, mult3_B, mult2_B, mult1_B} = opb_q;
  assign {sign_B3, sign_B2, sign_B1, sign_B0,
          sign_A3, sign_A2, sign_A1, sign_A0} = sgn_q;

endmodule

// File: tb/tb_multiplier_8.sv
// Self-checking bench for multiplier_8: directed + random vectors
// against an arithmetic reference model, plus async reset checks.
module tb_multiplier_8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in_A, data_in_B;
  logic [1:0]  sew;
  logic        count_0;
  logic [7:0]  m1a, m2a, m3a, m4a, m5a, m6a, m7a, m8a;
  logic [7:0]  m1b, m2b, m3b, m4b, m5b, m6b, m7b, m8b;
  logic        sa0, sa1, sa2, sa3, sb0, sb1, sb2, sb3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multiplier_8 dut (
    .clk(clk), .reset(reset),
    .data_in_A(data_in_A), .data_in_B(data_in_B),
    .sew(sew), .count_0(count_0),
    .mult1_A(m1a), .mult2_A(m2a), .mult3_A(m3a), .mult4_A(m4a),
    .mult5_A(m5a), .mult6_A(m6a), .mult7_A(m7a), .mult8_A(m8a),
    .mult1_B(m1b), .mult2_B(m2b), .mult3_B(m3b), .mult4_B(m4b),
    .mult5_B(m5b), .mult6_B(m6b), .mult7_B(m7b), .mult8_B(m8b),
    .sign_A0(sa0), .sign_A1(sa1), .sign_A2(sa2), .sign_A3(sa3),
    .sign_B0(sb0), .sign_B1(sb1), .sign_B2(sb2), .sign_B3(sb3)
  );

  wire [63:0] got_a = {m8a, m7a, m6a, m5a, m4a, m3a, m2a, m1a};
  wire [63:0] got_b = {m8b, m7b, m6b, m5b, m4b, m3b, m2b, m1b};
  wire [7:0]  got_s = {sb3, sb2, sb1, sb0, sa3, sa2, sa1, sa0};

`ifdef MULT8_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Per-element magnitudes packed back into a 32-bit word.
  function automatic logic [31:0] mags(input logic [31:0] x, input int w);
    longint unsigned word = 0;
    longint unsigned mod = 64'd1 << w;
    for (int e = 0; e < 32 / w; e++) begin
      longint unsigned el = (longint'(x) >> (e * w)) % mod;
      if (SIGNED && el >= mod / 2) el = mod - el;
      word = word | ((el % mod) << (e * w));
    end
    return word[31:0];
  endfunction

  function automatic logic [7:0] byt(input logic [31:0] w, input int i);
    return w[8*i +: 8];
  endfunction

  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] s, input logic c,
                       output logic [63:0] ea, output logic [63:0] eb,
                       output logic [7:0] es);
    int ia[8], ib[8];
    int w;
    logic [31:0] ma, mb;
    ea = '0; eb = '0; es = '0;
    if (s == 2'b11) return;
    w  = (s == 2'b00) ? 8 : (s == 2'b01) ? 16 : 32;
    ma = mags(a, w);
    mb = mags(b, w);
    for (int k = 0; k < 8; k++) begin
      ia[k] = -1; ib[k] = -1;
      case (s)
        2'b00: if (k < 4) begin ia[k] = k; ib[k] = k; end
        2'b01: begin
          ia[k] = (k / 4) * 2 + (k % 4) / 2;
          ib[k] = (k / 4) * 2 + (k % 2);
        end
        default: begin
          ia[k] = k % 4;
          ib[k] = (c ? 2 : 0) + k / 4;
        end
      endcase
      if (ia[k] >= 0) ea[8*k +: 8] = byt(ma, ia[k]);
      if (ib[k] >= 0) eb[8*k +: 8] = byt(mb, ib[k]);
    end
    if (SIGNED) begin
      for (int e = 0; e < 32 / w; e++) begin
        es[e]     = a[e*w + w - 1];
        es[4 + e] = b[e*w + w - 1];
      end
    end
  endtask

  task automatic apply(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] s,
                       input logic c);
    logic [63:0] ea, eb;
    logic [7:0]  es;
    @(negedge clk);
    data_in_A = a; data_in_B = b; sew = s; count_0 = c;
    model(a, b, s, c, ea, eb, es);
    @(posedge clk);
    #1;
    chk({tag, ".A"}, got_a, ea);
    chk({tag, ".B"}, got_b, eb);
    chk({tag, ".S"}, {56'd0, got_s}, {56'd0, es});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".A"}, got_a, 64'd0);
    chk({tag, ".B"}, got_b, 64'd0);
    chk({tag, ".S"}, {56'd0, got_s}, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    data_in_A = 32'hFFFF_FFFF; data_in_B = 32'hFFFF_FFFF;
    sew = 2'b00; count_0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst_init");
    @(negedge clk);
    reset = 1'b0;

    apply("s8_ff",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b0);
    apply("s8_mix",  32'h1122_3344, 32'hAABB_CCDD, 2'b00, 1'b0);
    apply("s16_ff",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 1'b0);
    apply("s32_c0",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 1'b0);
    apply("s32_c1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 1'b1);
    apply("s11",     32'h1234_5678, 32'h9ABC_DEF0, 2'b11, 1'b1);
    apply("s8_80",   32'h8080_8080, 32'h7F01_80FF, 2'b00, 1'b1);
    apply("s16_8k",  32'h8000_8000, 32'h7FFF_0001, 2'b01, 1'b1);
    apply("s32_min", 32'h8000_0000, 32'h8000_0000, 2'b10, 1'b0);
    apply("s32_neg", 32'hFEDC_BA98, 32'h8765_4321, 2'b10, 1'b1);

    // Reset dropped in between edges must clear outputs at once.
    apply("pre_rst", 32'h8123_4567, 32'hC0FF_EE11, 2'b01, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("rst_async");
    @(posedge clk);
    #1;
    chk_zero("rst_hold");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 300; i++) begin
      apply("rand", $urandom, $urandom,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplier_8.md
Name: multiplier_8

Overview:
- Operand-preparation stage of the 32-bit SIMD vector multiplier.
- Converts two 32-bit source words into eight registered 8-bit operand pairs and per-element sign bits, according to element width `sew`.
- The pairs feed eight downstream 8x8 unsigned multipliers, whose partial products are later shifted, summed and sign-corrected.
- For 32-bit elements the 16 partial products are produced over two passes, selected by `count_0`.

Parameters:
- None. All widths are fixed: 32-bit data, 8-bit lanes, 8 multiplier pairs.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- data_in_A  input  32  multiplicand word
- data_in_B  input  32  multiplier word
- sew  input  2  element width: 00=8b, 01=16b, 10=32b, 11=reserved
- count_0  input  1  32-bit pass select: 0=low half of B, 1=high half of B
- mult1_A..mult8_A  output  8 each  A-side operand of multiplier k
- mult1_B..mult8_B  output  8 each  B-side operand of multiplier k
- sign_A0..sign_A3  output  1 each  sign of A element e
- sign_B0..sign_B3  output  1 each  sign of B element e

Behaviour:
- All outputs are registered and update on the rising edge of `clk`: one-cycle latency from inputs.
- `reset` asserted, at any time including mid-operation, clears every output to 0 immediately; no other state exists.
- Signed two's-complement elements; magnitude |x| = x if MSB=0, else (~x+1) truncated to the element width.
  - Most-negative values map to their unsigned magnitude: 0x80 -> 0x80, 0x8000 -> 0x8000, 0x80000000 -> 0x80000000.
  - Sign bit = element MSB.
- Let a0..a3 / b0..b3 be the bytes (LSB first) of the per-element magnitudes of A / B.
- sew=00 (four 8-bit elements):
  - multk_A = a(k-1), multk_B = b(k-1) for k=1..4.
  - mult5..8 = 0.
  - sign_Ae = A[8e+7], sign_Be = B[8e+7].
- sew=01 (two 16-bit elements, each magnitude taken over 16 bits):
  - Element 0 pairs: mult1=(a0,b0), mult2=(a0,b1), mult3=(a1,b0), mult4=(a1,b1).
  - Element 1 pairs: mult5=(a2,b2), mult6=(a2,b3), mult7=(a3,b2), mult8=(a3,b3).
  - sign_A0=A[15], sign_A1=A[31], sign_A2/3=0; sign_B likewise.
- sew=10 (one 32-bit element, magnitude over 32 bits):
  - count_0=0: A side = a0,a1,a2,a3,a0,a1,a2,a3; B side = b0,b0,b0,b0,b1,b1,b1,b1.
  - count_0=1: same A side; B side = b2,b2,b2,b2,b3,b3,b3,b3.
  - sign_A0=A[31], sign_B0=B[31]; other sign bits 0.
- `count_0` is ignored unless sew=10.
- sew=11: all operand and sign outputs are registered as 0.

Optional Feature:
- Macro: MULT8_SIGNED_EN.
- Defined: signed magnitude conversion and sign outputs exactly as above.
- Undefined: operands are treated as unsigned. Raw bytes pass through with the same lane mapping, no negation, and all sign outputs are 0.
- Reset, latency and lane mapping are identical in both builds.

Decomposition:
- Shared package `mult_pkg`:
  - `sew_e` enum (SEW_8=2'b00, SEW_16=2'b01, SEW_32=2'b10, SEW_RSVD=2'b11).
  - Constants NUM_MULT=8, LANE_W=8, DATA_W=32.
- One natural sub-module `mult_abs`: width-agnostic two's-complement magnitude/sign extractor, instantiated per element width. The lane mux and output registers stay in the top level.

Test Plan:
- Reset: assert `reset` asynchronously mid-stream -> all mult*/sign* outputs read 0 before the next clock edge; they stay 0 until release.
- sew=00, A=0xFFFFFFFF, B=0xFFFFFFFF -> next cycle A: 01 01 01 01 00 00 00 00, B: 01 01 01 01 00 00 00 00; all eight sign bits = 1.
- sew=00, A=0x11223344, B=0xAABBCCDD -> A: 44 33 22 11 00 00 00 00, B: 23 34 45 56 00 00 00 00; sign_A*=0, sign_B*=1.
- sew=01, A=B=0xFFFFFFFF -> A: 01 01 00 00 01 01 00 00, B: 01 00 01 00 01 00 01 00; sign_A0/A1/B0/B1=1, sign_A2/A3/B2/B3=0.
- sew=10, A=B=0xFFFFFFFF, count_0=0 -> A: 01 00 00 00 01 00 00 00, B: 01 01 01 01 00 00 00 00. Then count_0=1 -> A unchanged, B all 00. sign_A0=sign_B0=1, others 0.
- sew=11 with any data, and sew=00 with A=0x80808080 -> all-zero outputs for sew=11; for the second case mult1..4_A=0x80 with sign_A0..3=1 (0x80 -> 0x80 boundary).
